// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, fetch granule and buffer entry.
// HALT is only present when IFU_PREFETCH_MISALIGN_CHK_EN is defined.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
    ,
    HALT = 2'd2
`endif
  } fetch_state_t;

  localparam int unsigned INST_BYTES = 4;

  // Entry layout at the default 32-bit widths; the top builds the same shape from its parameters.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Parametrised synchronous FIFO with flush; the head word is read straight from the storage register.
module ifu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Pipelined instruction fetch with in-order prefetch buffer and flush-time discard of stale responses.
// Optional misaligned-redirect halt is enabled by defining IFU_PREFETCH_MISALIGN_CHK_EN.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          FIFO_DEPTH      = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  input  logic                  hold_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_data_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
  ,
  output logic                  misalign_err_o
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, flush_tgt, pcq_head;
  logic [OW-1:0]         discard_q, discard_d, pcq_cnt, outst;
  logic [FW-1:0]         fifo_cnt;
  logic                  pcq_full, pcq_empty, fifo_full, fifo_empty;
  logic                  req_hs, rsp_ok, rsp_keep;
  entry_t                push_entry, head_entry;

`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
  logic misalign, err_q;
  assign misalign       = (flush_pc_i[1:0] != 2'b00);
  assign flush_tgt      = flush_pc_i;
  assign misalign_err_o = err_q;
`else
  assign flush_tgt = flush_pc_i & ~ADDR_WIDTH'(3);
`endif

  // In flight = live requests tracked in the pc queue plus stale ones awaiting discard.
  assign outst = pcq_cnt + discard_q;

  assign mem_req_valid_o = (state_q == RUN) & ~hold_i & ~pcq_full & ~fifo_full &
                           (32'(outst) < MAX_OUTSTANDING) &
                           ((32'(outst) + 32'(fifo_cnt)) < FIFO_DEPTH);
  assign mem_req_addr_o  = fetch_pc_q;
  assign req_hs          = mem_req_valid_o & mem_req_ready_i;
  assign rsp_ok          = mem_rsp_valid_i & (outst != '0);
  assign rsp_keep        = rsp_ok & (discard_q == '0) & ~flush_i & ~pcq_empty;

  assign push_entry   = '{pc: pcq_head, data: mem_rsp_data_i};
  assign inst_valid_o = ~fifo_empty;
  assign inst_pc_o    = head_entry.pc;
  assign inst_data_o  = head_entry.data;

  always_comb begin
    discard_d = discard_q;
    if (flush_i) discard_d = outst + OW'(req_hs) - OW'(rsp_ok);
    else if (rsp_ok && discard_q != '0) discard_d = discard_q - 1'b1;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush_i) fetch_pc_d = flush_tgt;
    else if (req_hs) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
      if (flush_i) err_q <= misalign;
      case (state_q)
        IDLE:    state_q <= (flush_i && misalign) ? HALT : RUN;
        RUN:     if (flush_i && misalign) state_q <= HALT;
        HALT:    if (flush_i && !misalign) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
`else
      case (state_q)
        IDLE:    state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= IDLE;
      endcase
`endif
    end
  end

  ifu_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_hs & ~flush_i),
    .pop_i   (rsp_keep),
    .flush_i (flush_i),
    .data_i  (fetch_pc_q),
    .data_o  (pcq_head),
    .count_o (pcq_cnt),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

  ifu_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_keep),
    .pop_i   (inst_ready_i),
    .flush_i (flush_i),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch against an in-order memory model with 1-cycle latency.
// Build with IFU_PREFETCH_MISALIGN_CHK_EN defined to exercise the misalign halt path.
`timescale 1ns/1ps
module tb_ifu_prefetch;

  logic        clk, rst;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        flush_i, hold_i;
  logic [31:0] flush_pc_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_data_o, inst_pc_o;
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
  logic        misalign_err_o;
`endif

  int          total, bad;
  logic        rsp_en;
  logic [31:0] pend [$];
  logic        hs, pop;

  assign hs  = mem_req_valid_o & mem_req_ready_i;
  assign pop = inst_valid_o & inst_ready_i;

  ifu_prefetch #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .hold_i          (hold_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_data_o     (inst_data_o),
    .inst_pc_o       (inst_pc_o)
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
    ,
    .misalign_err_o  (misalign_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: accepts every handshake, answers in order one cycle later while rsp_en is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      mem_rsp_valid_i <= 1'b0;
      mem_rsp_data_i  <= '0;
    end else begin
      if (mem_req_valid_o && mem_req_ready_i) pend.push_back(mem_req_addr_o);
      if (rsp_en && pend.size() != 0) begin
        mem_rsp_valid_i <= 1'b1;
        mem_rsp_data_i  <= mem_word(pend.pop_front());
      end else begin
        mem_rsp_valid_i <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0; hold_i = 1'b0;
    inst_ready_i = 1'b1; mem_req_ready_i = 1'b1; rsp_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0; hold_i = 1'b0;
    inst_ready_i = 1'b1; mem_req_ready_i = 1'b1; rsp_en = 1'b1;
    #2;
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid_o); end
    total++; if (mem_req_addr_o !== 32'h0) begin bad++; $display("FAIL rst_req_addr: got %h want 0", mem_req_addr_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid_o); end
    total++; if (inst_data_o !== 32'h0) begin bad++; $display("FAIL rst_inst_data: got %h want 0", inst_data_o); end
    total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc_o); end
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
    total++; if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", misalign_err_o); end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL idle_cycle_req: got %b want 0", mem_req_valid_o); end
    @(negedge clk); #1;
    total++; if (mem_req_valid_o !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", mem_req_valid_o); end
    total++; if (mem_req_addr_o !== 32'h0) begin bad++; $display("FAIL first_req_addr: got %h want 0", mem_req_addr_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, exp_pc;
    int npop, gap;
    do_reset();
    exp_req = 32'h0; exp_pc = 32'h0; npop = 0; gap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hs) begin
        total++; if (mem_req_addr_o !== exp_req) begin bad++; $display("FAIL stream_req_addr: got %h want %h", mem_req_addr_o, exp_req); end
        exp_req += 32'h4;
      end
      if (pop) begin
        total++; if (inst_pc_o !== exp_pc || inst_data_o !== mem_word(exp_pc)) begin
          bad++; $display("FAIL stream_inst: got pc %h data %h want pc %h data %h", inst_pc_o, inst_data_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'h4; npop++;
      end else if (npop > 0) gap++;
    end
    total++; if (npop !== 37) begin bad++; $display("FAIL stream_pop_count: got %0d want 37", npop); end
    total++; if (gap !== 0) begin bad++; $display("FAIL stream_bubbles: got %0d want 0", gap); end
  endtask

  task automatic test_fill();
    int nreq;
    do_reset();
    inst_ready_i = 1'b0; nreq = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); #1;
      if (hs) nreq++;
    end
    total++; if (nreq !== 4) begin bad++; $display("FAIL fill_req_count: got %0d want 4", nreq); end
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL fill_req_stop: got %b want 0", mem_req_valid_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); inst_ready_i = 1'b1; #1;
      total++; if (pop !== 1'b1 || inst_pc_o !== 32'(4 * i) || inst_data_o !== mem_word(32'(4 * i))) begin
        bad++; $display("FAIL fill_drain: got valid %b pc %h data %h want pc %h", pop, inst_pc_o, inst_data_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_flush_stale();
    int nreq, npop;
    logic first_hs;
    logic [31:0] exp_pc;
    do_reset();
    rsp_en = 1'b0; nreq = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (hs) nreq++;
    end
    total++; if (nreq !== 2) begin bad++; $display("FAIL stale_outstanding: got %0d want 2", nreq); end
    @(negedge clk); flush_i = 1'b1; flush_pc_i = 32'h100; rsp_en = 1'b1; #1;
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL stale_flush_req: got %b want 0", mem_req_valid_o); end
    first_hs = 1'b1; npop = 0; exp_pc = 32'h100;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); flush_i = 1'b0; #1;
      if (i == 0) begin
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL stale_post_valid: got %b want 0", inst_valid_o); end
        total++; if (mem_req_addr_o !== 32'h100) begin bad++; $display("FAIL stale_post_addr: got %h want 100", mem_req_addr_o); end
      end
      if (hs && first_hs) begin
        first_hs = 1'b0;
        total++; if (mem_req_addr_o !== 32'h100) begin bad++; $display("FAIL stale_first_req: got %h want 100", mem_req_addr_o); end
      end
      if (pop) begin
        total++; if (inst_pc_o !== exp_pc || inst_data_o !== mem_word(exp_pc)) begin
          bad++; $display("FAIL stale_inst: got pc %h data %h want pc %h", inst_pc_o, inst_data_o, exp_pc);
        end
        exp_pc += 32'h4; npop++;
      end
    end
    total++; if (npop == 0) begin bad++; $display("FAIL stale_no_inst: got 0 pops want >0"); end
  endtask

  task automatic test_flush_same_cycle();
    int npop;
    logic [31:0] exp_pc;
    do_reset();
    for (int c = 0; c < 6; c++) @(negedge clk);
    @(negedge clk); flush_i = 1'b1; flush_pc_i = 32'h80; #1;
    total++; if (hs !== 1'b1 || mem_rsp_valid_i !== 1'b1) begin
      bad++; $display("FAIL same_cycle_setup: got hs %b rsp %b want 1 1", hs, mem_rsp_valid_i);
    end
    npop = 0; exp_pc = 32'h80;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); flush_i = 1'b0; #1;
      if (i == 0) begin
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL same_post_valid: got %b want 0", inst_valid_o); end
        total++; if (mem_req_addr_o !== 32'h80) begin bad++; $display("FAIL same_post_addr: got %h want 80", mem_req_addr_o); end
      end
      if (pop) begin
        total++; if (inst_pc_o !== exp_pc || inst_data_o !== mem_word(exp_pc)) begin
          bad++; $display("FAIL same_inst: got pc %h data %h want pc %h", inst_pc_o, inst_data_o, exp_pc);
        end
        exp_pc += 32'h4; npop++;
      end
    end
    total++; if (npop == 0) begin bad++; $display("FAIL same_no_inst: got 0 pops want >0"); end
  endtask

  task automatic test_hold();
    logic [31:0] exp_req, exp_pc;
    int hold_pops, late_reqs;
    do_reset();
    exp_req = 32'h0; exp_pc = 32'h0; hold_pops = 0; late_reqs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); hold_i = (c >= 10 && c < 15); #1;
      if (hold_i) begin
        total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL hold_req: got %b want 0", mem_req_valid_o); end
        if (pop) hold_pops++;
      end
      if (hs) begin
        total++; if (mem_req_addr_o !== exp_req) begin bad++; $display("FAIL hold_req_addr: got %h want %h", mem_req_addr_o, exp_req); end
        exp_req += 32'h4;
        if (c >= 15) late_reqs++;
      end
      if (pop) begin
        total++; if (inst_pc_o !== exp_pc || inst_data_o !== mem_word(exp_pc)) begin
          bad++; $display("FAIL hold_inst: got pc %h data %h want pc %h", inst_pc_o, inst_data_o, exp_pc);
        end
        exp_pc += 32'h4;
      end
    end
    hold_i = 1'b0;
    total++; if (hold_pops !== 2) begin bad++; $display("FAIL hold_drain: got %0d want 2", hold_pops); end
    total++; if (late_reqs !== 15) begin bad++; $display("FAIL hold_resume: got %0d want 15", late_reqs); end
  endtask

  task automatic test_misalign();
    logic first_hs, first_pop;
    logic [31:0] tgt;
    do_reset();
    for (int c = 0; c < 6; c++) @(negedge clk);
    @(negedge clk); flush_i = 1'b1; flush_pc_i = 32'h102;
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); flush_i = 1'b0; #1;
      if (i == 0) begin
        total++; if (misalign_err_o !== 1'b1) begin bad++; $display("FAIL mis_err_set: got %b want 1", misalign_err_o); end
      end
      total++; if (mem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        bad++; $display("FAIL mis_halt: got req %b inst %b want 0 0", mem_req_valid_o, inst_valid_o);
      end
    end
    @(negedge clk); flush_i = 1'b1; flush_pc_i = 32'h200;
    tgt = 32'h200;
`else
    tgt = 32'h100;
`endif
    first_hs = 1'b1; first_pop = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); flush_i = 1'b0; #1;
`ifdef IFU_PREFETCH_MISALIGN_CHK_EN
      if (i == 0) begin
        total++; if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL mis_err_clr: got %b want 0", misalign_err_o); end
      end
`endif
      if (hs && first_hs) begin
        first_hs = 1'b0;
        total++; if (mem_req_addr_o !== tgt) begin bad++; $display("FAIL mis_resume_addr: got %h want %h", mem_req_addr_o, tgt); end
      end
      if (pop && first_pop) begin
        first_pop = 1'b0;
        total++; if (inst_pc_o !== tgt || inst_data_o !== mem_word(tgt)) begin
          bad++; $display("FAIL mis_resume_inst: got pc %h data %h want pc %h", inst_pc_o, inst_data_o, tgt);
        end
      end
    end
    total++; if (first_hs || first_pop) begin bad++; $display("FAIL mis_no_resume: got hs_pending %b pop_pending %b want 0 0", first_hs, first_pop); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_fill();
    test_flush_stale();
    test_flush_same_cycle();
    test_hold();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with an in-order prefetch buffer. It replaces the single-request fetch handshake with a pipelined requester. It keeps up to MAX_OUTSTANDING fetches in flight to instruction memory (ROM or bus) and buffers returned words in a FIFO_DEPTH-entry queue. It presents {pc, instruction} pairs to the decoder (`id`) with valid/ready flow control, and supports redirect (flush) from the execute stage with discard of stale in-flight responses.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width
- DATA_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- MAX_OUTSTANDING, 2, memory requests in flight; 1..FIFO_DEPTH
- RESET_PC, 32'h0, first fetch address after reset

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req_valid_o  out  1  fetch request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  fetch address
- mem_rsp_valid_i  in  1  response word valid; responses return in order, no backpressure
- mem_rsp_data_i  in  DATA_WIDTH  response word
- flush_i  in  1  redirect fetch stream
- flush_pc_i  in  ADDR_WIDTH  redirect target
- hold_i  in  1  stop issuing new requests; buffered data still drains
- inst_valid_o  out  1  instruction available
- inst_ready_i  in  1  decoder consumes
- inst_data_o  out  DATA_WIDTH  instruction word
- inst_pc_o  out  ADDR_WIDTH  address of inst_data_o
- misalign_err_o  out  1  sticky misaligned-redirect flag; present only with the macro

## Operation
- FSM states: IDLE, RUN, HALT (HALT exists only with the macro).
  - Reset → IDLE.
  - IDLE → RUN after one cycle.
  - RUN → HALT on misaligned flush.
  - HALT → RUN on aligned flush.
- Fetch counter fetch_pc starts at RESET_PC and advances by 4 on each request handshake (mem_req_valid_o & mem_req_ready_i). It wraps modulo 2^ADDR_WIDTH.
- mem_req_valid_o = RUN & !hold_i & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < FIFO_DEPTH).
  - Every accepted request therefore has a reserved FIFO slot.
  - A response is never dropped for lack of space.
- A pc queue (depth MAX_OUTSTANDING) records the address of each accepted request. On response, {pc, data} is pushed to the FIFO.
- Discard counter:
  - flush_i loads discard = outstanding + (request handshake this cycle) − (response this cycle).
  - While discard > 0, each response decrements it and is dropped, with no FIFO push.
  - A response arriving while outstanding == 0 is a protocol violation and is ignored.
- Flush, next cycle:
  - FIFO and pc queue are empty.
  - fetch_pc = flush_pc_i.
  - inst_valid_o = 0.
  - A decoder pop in the flush cycle is allowed.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- hold_i does not block responses or pops.

## Timing
- Reset values:
  - mem_req_valid_o = 0.
  - mem_req_addr_o = RESET_PC.
  - inst_valid_o = 0.
  - inst_data_o = 0.
  - inst_pc_o = 0.
  - misalign_err_o = 0.
  - All counters = 0.
- First request is asserted in the second cycle after rst deasserts (the IDLE cycle).
- mem_req_valid_o and mem_req_addr_o depend only on registered state and hold_i. No combinational path from the response or decoder inputs.
- Response in cycle N → inst_valid_o in cycle N+1. Sustained throughput is 1 instruction/cycle when the memory has 1-cycle latency and MAX_OUTSTANDING ≥ 2.
- inst_* outputs come from the FIFO head register and hold stable while inst_valid_o & !inst_ready_i.
- rst asserted mid-operation clears all state immediately. Late responses after reset are ignored via outstanding == 0.

## Configuration
- IFU_PREFETCH_MISALIGN_CHK_EN defined:
  - flush_pc_i[1:0] != 0 sets misalign_err_o.
  - The FSM enters HALT: no requests, FIFO flushed.
  - An aligned flush clears the error and resumes.
- Not defined:
  - flush_pc_i[1:0] is forced to 0.
  - No HALT state and no misalign_err_o port.

## Structure
- Shared package ifu_pkg: fetch_state_t enum (IDLE/RUN/HALT), INST_BYTES = 4, and the {pc, data} entry struct.
- One sub-module: ifu_fifo, a parametrised synchronous FIFO (width, depth; push/pop/flush, count, full/empty). It is instantiated for the prefetch buffer and for the pc queue.

## Test plan
- Reset release, memory always ready with 1-cycle latency:
  - mem_req_addr_o sequence 0x0, 0x4, 0x8…
  - inst_pc_o 0x0, 0x4… on consecutive cycles after fill.
- inst_ready_i held 0: exactly FIFO_DEPTH (4) requests are accepted, then mem_req_valid_o = 0. Releasing ready drains 4 entries in order.
- Flush to 0x100 with 2 requests outstanding: both stale responses are dropped. The next inst_pc_o is 0x100.
- Flush, request handshake and response all in the same cycle: discard = outstanding + 1 − 1. No stale word reaches the decoder.
- hold_i for 5 cycles mid-stream: no new requests; buffered instructions still issue; fetch resumes at the correct next pc.
- Macro on, flush_pc_i = 0x102:
  - misalign_err_o = 1 and no requests.
  - A subsequent flush to 0x200 clears the flag and fetch resumes at 0x200.
- Macro off, same stimulus: fetch resumes at 0x100.
